chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//  Parametrised multi-cycle adder built from the half/full-adder primitive: adds two WIDTH-bit
//  operands plus carry-in, CHUNK bits per clock, LSB chunk first, with a registered carry chain.
//  Valid/ready handshake on input and output. Optional accumulate mode replaces operand A with
//  the last result. Serves as the area-scalable arithmetic block for datapaths that tolerate latency.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; must be >= 1
//  CHUNK   2   bits added per cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise)
//  NCHUNK  derived, WIDTH/CHUNK; cycles per operation; not user-overridable (localparam)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block idle and able to accept
//  a          in   WIDTH  operand A (ignored when acc_mode=1)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to LSB
//  acc_mode   in   1      1: A := accumulator register, sampled with the operands
//  acc_clr    in   1      clears accumulator to 0; honoured only in IDLE
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, registered
//  cout       out  1      carry out of MSB
//  ovf        out  1      two's-complement overflow
// BEHAVIOUR
//  Reset (rst_n low, immediate, any state): state=IDLE; sum=0, cout=0, ovf=0, out_valid=0,
//   in_ready=0, accumulator=0, chunk index=0, carry=0. in_ready=1 from first edge after release.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept on in_valid&&in_ready at edge: latch opA (a, or acc if acc_mode),
//   b, carry=cin, idx=0; go RUN. acc_clr in same cycle as accepted acc_mode op: opA=0 and acc=0.
//  RUN: in_ready=0. Each edge: {carry, sum[idx*CHUNK +: CHUNK]} = opA chunk + b chunk + carry;
//   idx++. On last chunk (idx==NCHUNK-1): cout=carry out, ovf=(opA[MSB]==b[MSB]) &&
//   (sum[MSB]!=opA[MSB]), acc:=full sum, go DONE.
//  Latency: out_valid rises NCHUNK edges after accept edge (WIDTH=8,CHUNK=2 -> 4 cycles).
//  DONE: out_valid=1; sum/cout/ovf held stable until out_ready. On out_valid&&out_ready edge:
//   out_valid=0, go IDLE. No same-cycle new accept in DONE (in_ready=0); throughput 1 op per
//   NCHUNK+2 cycles minimum.
//  Partial sum bits visible on sum during RUN are don't-care; consumers use only out_valid.
//  in_valid/operand changes while not IDLE are ignored. acc_clr outside IDLE ignored.
//  Arithmetic modulo 2^WIDTH; cout is the unsigned overflow; WIDTH=1,CHUNK=1,cin=0 degenerates
//   to half adder (sum=a^b, cout=a&b) after 1 cycle.
//  Reset mid-RUN/DONE: operation discarded, no out_valid produced, accumulator lost.
// TESTING
//  T1 WIDTH=1,CHUNK=1,cin=0: (a,b)=00,01,10,11 -> (cout,sum)=00,01,01,10; out_valid 1 cycle after accept.
//  T2 W=8,C=2: a=0xFF,b=0x01,cin=0 -> sum=0x00,cout=1,ovf=0; out_valid exactly 4 edges after accept.
//  T3 W=8,C=2: a=0x7F,b=0x01 -> sum=0x80,cout=0,ovf=1; a=0x80,b=0x80 -> sum=0x00,cout=1,ovf=1.
//  T4 Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum/cout/ovf stable, in_ready=0, new in_valid ignored.
//  T5 Accumulate: acc_clr in IDLE, then three ops acc_mode=1,b=0x10,cin=0 -> sums 0x10,0x20,0x30.
//  T6 Drop rst_n mid-RUN -> all outputs 0 same cycle, no result; after release a=0x12,b=0x34 -> sum=0x46.
//  Also sweep W=16,C in {1,4,16}: random operands vs. reference model, latency == NCHUNK.

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
// Handshake/operand bundle for chunked_serial_adder.
//   in_valid/in_ready    operand handshake (producer -> adder)
//   a, b, cin            operands and carry-in
//   acc_mode, acc_clr    accumulate select / accumulator clear
//   out_valid/out_ready  result handshake (adder -> consumer)
//   sum, cout, ovf       result, unsigned carry out, signed overflow
// master: the side that supplies operands and consumes results.
// slave : the adder itself.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             acc_mode;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, acc_mode, acc_clr, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, acc_mode, acc_clr, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits
// per clock (LSB chunk first) through a ripple of full adders, with the
// carry between chunks held in a register. Result appears NCHUNK edges
// after the accept edge and is held until the consumer takes it.
// Optional accumulate mode uses the previous result as operand A.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    chunked_serial_adder_if.slave (handshakes, operands, result)
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_serial_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("chunked_serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_op_a;     // shifts right one chunk per RUN cycle
  logic [WIDTH-1:0] r_op_b;
  logic             r_a_msb;    // operand sign bits, kept for overflow
  logic             r_b_msb;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_op_a_load;
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_s;
  logic [WIDTH+CHUNK-1:0] w_sum_cat;
  logic [WIDTH-1:0] w_sum_next;

  assign w_accept = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
  assign w_last   = (r_idx == LAST_IDX);

  // acc_clr alongside an accumulate op forces A to zero for that op.
  assign w_op_a_load = bus.acc_mode ? (bus.acc_clr ? '0 : r_acc) : bus.a;

  // Full-adder ripple across the current chunk (low CHUNK bits of the
  // shifting operand registers).
  assign w_c[0] = r_carry;
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign w_s[gi]     = r_op_a[gi] ^ r_op_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (r_op_a[gi] & r_op_b[gi]) |
                           (w_c[gi] & (r_op_a[gi] ^ r_op_b[gi]));
    end
  endgenerate

  // New chunk enters at the top; after NCHUNK cycles the LSB chunk has
  // shifted down to bit 0 and the sum register holds the full result.
  assign w_sum_cat  = {w_s, r_sum};
  assign w_sum_next = w_sum_cat[WIDTH+CHUNK-1:CHUNK];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)      w_state_next = S_RUN;
      S_RUN:  if (w_last)        w_state_next = S_DONE;
      S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_acc      <= '0;
      r_in_ready <= 1'b0;
    end else begin
      // Registered so that in_ready stays low while reset is asserted and
      // rises on the first edge after release.
      r_in_ready <= (w_state_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.acc_clr) begin
            r_acc <= '0;
          end
          if (w_accept) begin
            r_op_a  <= w_op_a_load;
            r_op_b  <= bus.b;
            r_a_msb <= w_op_a_load[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_carry <= bus.cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c[CHUNK];
          r_op_a  <= r_op_a >> CHUNK;
          r_op_b  <= r_op_b >> CHUNK;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_c[CHUNK];
            r_ovf  <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
            r_acc  <= w_sum_next;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          // DONE: result held until accepted
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_serial_adder.sv
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  chunked_serial_adder_if #(.WIDTH(1))  if1 ();
  chunked_serial_adder_if #(.WIDTH(8))  if8 ();
  chunked_serial_adder_if #(.WIDTH(16)) if16_c1 ();
  chunked_serial_adder_if #(.WIDTH(16)) if16_c4 ();
  chunked_serial_adder_if #(.WIDTH(16)) if16_c16 ();

  chunked_serial_adder #(.WIDTH(1),  .CHUNK(1))  dut_w1    (.clk(clk), .rst_n(rst_n), .bus(if1));
  chunked_serial_adder #(.WIDTH(8),  .CHUNK(2))  dut_w8    (.clk(clk), .rst_n(rst_n), .bus(if8));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(1))  dut_w16c1 (.clk(clk), .rst_n(rst_n), .bus(if16_c1));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(4))  dut_w16c4 (.clk(clk), .rst_n(rst_n), .bus(if16_c4));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut_w16c16(.clk(clk), .rst_n(rst_n), .bus(if16_c16));

  // The three 16-bit instances see identical stimulus.
  logic        s16_valid, s16_cin, s16_accm, s16_accc, s16_oready;
  logic [15:0] s16_a, s16_b;
  assign if16_c1.in_valid  = s16_valid;  assign if16_c4.in_valid  = s16_valid;  assign if16_c16.in_valid  = s16_valid;
  assign if16_c1.a         = s16_a;      assign if16_c4.a         = s16_a;      assign if16_c16.a         = s16_a;
  assign if16_c1.b         = s16_b;      assign if16_c4.b         = s16_b;      assign if16_c16.b         = s16_b;
  assign if16_c1.cin       = s16_cin;    assign if16_c4.cin       = s16_cin;    assign if16_c16.cin       = s16_cin;
  assign if16_c1.acc_mode  = s16_accm;   assign if16_c4.acc_mode  = s16_accm;   assign if16_c16.acc_mode  = s16_accm;
  assign if16_c1.acc_clr   = s16_accc;   assign if16_c4.acc_clr   = s16_accc;   assign if16_c16.acc_clr   = s16_accc;
  assign if16_c1.out_ready = s16_oready; assign if16_c4.out_ready = s16_oready; assign if16_c16.out_ready = s16_oready;

  logic [7:0]  acc8;   // model accumulators
  logic [15:0] acc16;

  task automatic check(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, what, got, exp);
  endtask

  // Reference: plain integer addition, result = {ovf, cout, sum[15:0]}
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] full;
    logic [15:0] mask, s;
    logic co, ov;
    mask = 16'((17'd1 << w) - 17'd1);
    full = 17'(a & mask) + 17'(b & mask) + 17'(cin);
    s    = full[15:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic op1(input logic a, input logic b);
    int n;
    logic [17:0] r;
    r = ref_add(1, {15'h0, a}, {15'h0, b}, 1'b0);
    check("w1", "rdy", if1.in_ready, 1);
    if1.a = a; if1.b = b; if1.cin = 1'b0; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    n = 0;
    while (!if1.out_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("w1", "lat",  n, 1);
    check("w1", "sum",  if1.sum, r[0]);
    check("w1", "cout", if1.cout, r[16]);
    $display("w1: a=%0d b=%0d -> cout=%0d sum=%0d", a, b, if1.cout, if1.sum);
    if1.out_ready = 1'b1; @(posedge clk); #1; if1.out_ready = 1'b0;
  endtask

  // hold: cycles to stall in DONE while a competing request and acc_clr are driven
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic accm, input logic accc, input int hold);
    int n;
    logic [17:0] r;
    logic [7:0] opa;
    n = 0;
    while (!if8.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check(tag, "rdy", if8.in_ready, 1);
    opa = accm ? (accc ? 8'h00 : acc8) : a;
    r = ref_add(8, {8'h0, opa}, {8'h0, b}, cin);
    acc8 = r[7:0];
    if8.a = a; if8.b = b; if8.cin = cin; if8.acc_mode = accm; if8.acc_clr = accc; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.acc_mode = 1'b0; if8.acc_clr = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check(tag, "lat",  n, 4);
    check(tag, "sum",  if8.sum, r[7:0]);
    check(tag, "cout", if8.cout, r[16]);
    check(tag, "ovf",  if8.ovf, r[17]);
    for (int i = 0; i < hold; i++) begin
      if8.a = 8'hA5; if8.b = 8'h5A; if8.acc_clr = 1'b1; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      check(tag, "hold_sum",  if8.sum, r[7:0]);
      check(tag, "hold_cout", if8.cout, r[16]);
      check(tag, "hold_ovf",  if8.ovf, r[17]);
      check(tag, "hold_rdy",  if8.in_ready, 0);
      check(tag, "hold_ov",   if8.out_valid, 1);
    end
    if8.in_valid = 1'b0; if8.acc_clr = 1'b0;
    $display("%s: a=%02h b=%02h cin=%0d acc=%0d -> sum=%02h cout=%0d ovf=%0d", tag, a, b, cin, accm,
             if8.sum, if8.cout, if8.ovf);
    if8.out_ready = 1'b1; @(posedge clk); #1; if8.out_ready = 1'b0;
    check(tag, "ov_clr", if8.out_valid, 0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic accm, input logic accc);
    int n, lat1, lat4, lat16;
    logic [17:0] r;
    logic [15:0] opa;
    check("w16", "rdy", {if16_c1.in_ready, if16_c4.in_ready, if16_c16.in_ready}, 3'b111);
    opa = accm ? (accc ? 16'h0 : acc16) : a;
    r = ref_add(16, opa, b, cin);
    acc16 = r[15:0];
    s16_a = a; s16_b = b; s16_cin = cin; s16_accm = accm; s16_accc = accc; s16_valid = 1'b1;
    @(posedge clk); #1;
    s16_valid = 1'b0; s16_accm = 1'b0; s16_accc = 1'b0;
    lat1 = -1; lat4 = -1; lat16 = -1; n = 0;
    while (!(if16_c1.out_valid && if16_c4.out_valid && if16_c16.out_valid) && n < 40) begin
      @(posedge clk); #1; n++;
      if (if16_c1.out_valid  && lat1  < 0) lat1  = n;
      if (if16_c4.out_valid  && lat4  < 0) lat4  = n;
      if (if16_c16.out_valid && lat16 < 0) lat16 = n;
    end
    check("w16c1",  "lat", lat1,  16);
    check("w16c4",  "lat", lat4,  4);
    check("w16c16", "lat", lat16, 1);
    check("w16c1",  "res", {if16_c1.ovf,  if16_c1.cout,  if16_c1.sum},  r);
    check("w16c4",  "res", {if16_c4.ovf,  if16_c4.cout,  if16_c4.sum},  r);
    check("w16c16", "res", {if16_c16.ovf, if16_c16.cout, if16_c16.sum}, r);
    $display("w16: a=%04h b=%04h cin=%0d acc=%0d clr=%0d -> exp sum=%04h cout=%0d ovf=%0d",
             a, b, cin, accm, accc, r[15:0], r[16], r[17]);
    s16_oready = 1'b1; @(posedge clk); #1; s16_oready = 1'b0;
  endtask

  initial begin
    int n;
    if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.cin = 0; if1.acc_mode = 0; if1.acc_clr = 0; if1.out_ready = 0;
    if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.cin = 0; if8.acc_mode = 0; if8.acc_clr = 0; if8.out_ready = 0;
    s16_valid = 0; s16_a = 0; s16_b = 0; s16_cin = 0; s16_accm = 0; s16_accc = 0; s16_oready = 0;
    acc8 = 8'h0; acc16 = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst", "rdy",  if8.in_ready, 0);
    check("rst", "ov",   if8.out_valid, 0);
    check("rst", "res",  {if8.ovf, if8.cout, if8.sum}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel", "rdy", if8.in_ready, 1);

    // Half-adder degenerate case
    for (int i = 0; i < 4; i++) op1(i[1], i[0]);

    op8("t2",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0);
    op8("t3a", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 0);
    op8("t3b", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 0);
    op8("cin", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 0);

    // Backpressure; acc_clr driven while in DONE must not clear the accumulator
    op8("t4",    8'h3C, 8'h4D, 1'b1, 1'b0, 1'b0, 3);
    op8("t4acc", 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 0);

    // Accumulate from a cleared accumulator: 0x10, 0x20, 0x30
    if8.acc_clr = 1'b1; @(posedge clk); #1; if8.acc_clr = 1'b0;
    acc8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      op8("t5", 8'($urandom), 8'h10, 1'b0, 1'b1, 1'b0, 0);
      check("t5", "step", if8.sum, 8'(16 * (k + 1)));
    end
    op8("accclr", 8'h99, 8'h05, 1'b1, 1'b1, 1'b1, 0);

    // Reset in the middle of RUN
    if8.a = 8'h55; if8.b = 8'h66; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6", "rdy", if8.in_ready, 0);
    check("t6", "ov",  if8.out_valid, 0);
    check("t6", "res", {if8.ovf, if8.cout, if8.sum}, 0);
    acc8 = 8'h00; acc16 = 16'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (if8.out_valid) n++;
    end
    check("t6", "no_result", n, 0);
    op8("t6b",   8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 0);
    op8("t6acc", 8'hEE, 8'h01, 1'b0, 1'b1, 1'b0, 0);

    // 16-bit sweep over three chunk sizes
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op16(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      logic m;
      m = ($urandom_range(0, 3) == 0);
      op16(16'($urandom), 16'($urandom), 1'($urandom), m, m && ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
